// File: rtl/countdown_sequencer_pkg.sv
// Shared types for the countdown sequencer: state encoding, default width and
// the per-cycle action decode that fixes the clr > load > en priority.
package countdown_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_LOAD,
    ACT_STEP,
    ACT_TERM
  } action_t;

  // en only matters while running; a zero count makes the step terminal.
  function automatic action_t decode_action(input logic clr, input logic load,
                                            input logic run, input logic en,
                                            input logic zero);
    if (clr)             return ACT_CLEAR;
    else if (load)       return ACT_LOAD;
    else if (run && en)  return zero ? ACT_TERM : ACT_STEP;
    else                 return ACT_HOLD;
  endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between a loop controller (master) and the
// countdown sequencer (slave).
interface countdown_sequencer_if #(parameter int WIDTH = 8);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             bo;
  logic             done;

  modport master (
    output clr, load, load_val, en, auto_reload,
    input  count, busy, bo, done
  );

  modport slave (
    input  clr, load, load_val, en, auto_reload,
    output count, busy, bo, done
  );
endinterface

// File: rtl/countdown_sequencer.sv
// Loadable down-counter with borrow-out on the terminal step, a one-cycle done
// pulse after it, and optional self-reload for repeated periods.
module countdown_sequencer
  import countdown_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_sequencer_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  action_t          act;

  assign act = decode_action(bus.clr, bus.load, state_q == ST_RUN, bus.en,
                             count_q == '0);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (act)
      ACT_CLEAR: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
      ACT_LOAD: begin
        state_d  = ST_RUN;
        count_d  = bus.load_val;
        reload_d = bus.load_val;
      end
      ACT_STEP: count_d = count_q - WIDTH'(1);
      ACT_TERM: begin
        done_d = 1'b1;
        if (bus.auto_reload) count_d = reload_q;
        else                 state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.bo    = (state_q == ST_RUN) && (count_q == '0);
  assign bus.done  = done_q;

endmodule
